sprite_motion_ctrl: RTL and testbench
=====================================

# sprite_motion_ctrl

Game-object controller that owns the dragon, robot and missile sprite positions and valid flags consumed by the sprite renderer/collision block. It moves the player dragon from buttons, drives the robot and its missile autonomously, and reacts to the 2-bit collision `Event` that the renderer returns. It also maintains lives, score and the IDLE/PLAY/HIT/OVER game state.

## Interface

Parameters:
- `D_X0`, 40: dragon fixed x; also the dragon respawn x.
- `D_Y0`, 225: dragon reset/respawn y.
- `R_X0`, 560: robot spawn x.
- `Y_MAX`, 450: maximum top-left y for 30-row sprites (480−30).
- `D_STEP`, 4: dragon vertical pixels per tick.
- `R_STEP`, 2: robot pixels per tick, both x and y.
- `M_STEP`, 8: missile leftward pixels per tick.
- `FIRE_PERIOD`, 16: idle ticks between missile retire and the next launch.
- `HIT_TICKS`, 32: freeze length after a dragon hit.
- `LIVES`, 3: initial lives; 1–3.

Ports:
- `clk_22`, in, 1: game tick clock. Every rising edge is one tick. Single clock.
- `rst`, in, 1: **asynchronous, active-high reset**.
- `start`, in, 1: level; leaves IDLE or OVER.
- `btn_up`, `btn_down`, in, 1 each: levels; move the dragon.
- `Event`, in, 2: `{dragon_hit, robot_hit}` from the renderer, which runs in the pixel-clock domain. It is a level that is held for many ticks.
- `d_x`, `d_y`, `r_x`, `r_y`, `m_x`, `m_y`, out, 10 each: sprite top-left coordinates.
- `d_valid`, `r_valid`, `m_valid`, out, 1 each: sprite present.
- `lives`, out, 2: remaining lives.
- `score`, out, 8: robots destroyed, saturating at 255.
- `game_over`, out, 1: high in OVER.

## Operation

Reset values:
- State IDLE.
- `d_x`=`D_X0`, `d_y`=`D_Y0`, `r_x`=`R_X0`, `r_y`=0, `m_x`=`m_y`=0.
- All valids 0, `lives`=`LIVES`, `score`=0, `game_over`=0.
- Sync flops and `ev_prev` = 0, fire timer 0, hit timer 0, robot direction = down.

Event capture:
- `Event` passes through a 2-flop synchronizer, giving `ev_s`.
- A new event is `ev_s != 0 && ev_s != ev_prev`.
- `ev_prev <= ev_s` every tick.
- A held level produces exactly one action.

State machine:
- **IDLE**
  - All valids 0.
  - When `start`=1: reload positions to reset values, set `lives`=`LIVES`, `score`=0, and go to PLAY.
- **PLAY**
  - `d_valid`=`r_valid`=1.
  - Per tick, event handling is evaluated first. When an event fires, no movement occurs that tick.
- **HIT**
  - `d_valid` toggles every 4 ticks (blink). `r_valid` stays 1. `m_valid`=0.
  - There is no movement, and new events are ignored (`ev_prev` still tracks).
  - After `HIT_TICKS` ticks: `d_y`=`D_Y0`, go to PLAY.
- **OVER**
  - `game_over`=1, all valids 0, positions frozen.
  - When `start`=1: same reload as IDLE, then go to PLAY.

Movement in PLAY, per tick, absent an event:
- **Dragon:**
  - `btn_up` only: `d_y` −= `D_STEP`, clamped at 0.
  - `btn_down` only: `d_y` += `D_STEP`, clamped at `Y_MAX`.
  - Both or neither pressed: hold.
- **Robot vertical:** `r_y` moves ±`R_STEP`. Direction flips when the next value would pass 0 or `Y_MAX`; the value is clamped to that bound on the flip tick.
- **Robot horizontal:** `r_x` −= `R_STEP`. If `r_x < R_STEP`, then `r_x` wraps to `R_X0` that tick.
- **Missile:**
  - While `m_valid`=0, the fire timer increments.
  - When the timer reaches `FIRE_PERIOD` and `r_x >= 56+M_STEP`: launch with `m_x`=`r_x`−56, `m_y`=`r_y`+9, `m_valid`=1, and the timer clears.
  - If the launch condition fails, the timer holds at `FIRE_PERIOD` until it is satisfied.
  - While `m_valid`=1: `m_x` −= `M_STEP`. If `m_x < M_STEP`, then `m_valid`=0 and `m_x` is unchanged.

Event actions in PLAY:
- **`2'b01` (robot hit):**
  - `score`+1, saturating.
  - Robot respawns at `r_x`=`R_X0`, `r_y`=0, direction down.
  - Missile unaffected.
- **`2'b10` (dragon hit), or `2'b11` (both hit):**
  - `lives`−1. On `2'b11`, the robot also respawns; score is unchanged.
  - If `lives` was 1, go to OVER.
  - Otherwise go to HIT, with the hit timer cleared and missile cleared (`m_valid`=0, fire timer 0).

## Timing

- All outputs are registered.
- Event latency: the first tick at which `Event` is sampled stable, plus 2 synchronizer ticks plus 1 tick of output update, i.e. outputs change on the 3rd `clk_22` edge after `Event` is stable.
- `start`:
  - Sampled level.
  - PLAY outputs appear on the edge after `start` is seen in IDLE or OVER.
  - `start` is ignored in PLAY and HIT.
- `rst` mid-game:
  - Immediate asynchronous return to reset values.
  - The pending synchronizer contents are discarded.
- All arithmetic is 10-bit unsigned, with comparisons done before subtraction so no wrap below 0 ever reaches an output.
- `score` is 8-bit and saturating. `lives` decrements only from ≥1.

## Test plan

- **Reset:**
  - Stimulus: assert `rst`, release, hold `start`=0 for 10 ticks.
  - Required: state IDLE, all valids 0, `d_y`=225, `r_x`=560, `lives`=3, `score`=0.
- **Dragon clamp:**
  - Stimulus: `start` pulse, then `btn_up` for 60 ticks.
  - Required: `d_y` decreases 225→1 in steps of 4, then reads 0 and holds.
  - Stimulus: `btn_down` for 120 ticks.
  - Required: `d_y` reaches 450 and holds. Both buttons pressed: `d_y` unchanged.
- **Missile life cycle:**
  - Stimulus: in PLAY, wait 16 ticks.
  - Required: `m_valid`=1 with `m_x`=`r_x`−56 and `m_y`=`r_y`+9. `m_x` then drops by 8 per tick.
  - Required: `m_valid` goes to 0 on the first tick where `m_x`<8, and a relaunch follows 16 ticks later.
- **Robot-hit event:**
  - Stimulus: drive `Event`=01 held for 1000 ticks.
  - Required: `score`=1 exactly (not 1000); robot at (560,0) 3 ticks after assertion.
  - Stimulus: drop `Event` to 00, then raise to 01 again.
  - Required: `score`=2.
- **Dragon hit and game over:**
  - Stimulus: drive `Event`=10 (held for 10 ticks, then released).
  - Required: `lives`=2, HIT blink on `d_valid`, `m_valid`=0. After 32 ticks, PLAY with `d_y`=225.
  - Required: events during HIT are ignored.
  - Stimulus: two more hits.
  - Required: `lives`=0 via 1, `game_over`=1, all valids 0.
  - Stimulus: `start`.
  - Required: `lives`=3, `score`=0, PLAY.
- **Simultaneous and async:**
  - Stimulus: `Event`=11 held.
  - Required: `lives`−1, robot respawned, `score` unchanged.
  - Stimulus: assert `rst` mid-HIT.
  - Required: reset values immediately, without a clock edge.

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// Game-object controller: dragon/robot/missile positions, lives, score and
// the IDLE/PLAY/HIT/OVER game state, advanced once per game tick.
module sprite_motion_ctrl #(
    parameter logic [9:0] D_X0        = 10'd40,
    parameter logic [9:0] D_Y0        = 10'd225,
    parameter logic [9:0] R_X0        = 10'd560,
    parameter logic [9:0] Y_MAX       = 10'd450,
    parameter logic [9:0] D_STEP      = 10'd4,
    parameter logic [9:0] R_STEP      = 10'd2,
    parameter logic [9:0] M_STEP      = 10'd8,
    parameter int         FIRE_PERIOD = 16,
    parameter int         HIT_TICKS   = 32,
    parameter logic [1:0] LIVES       = 2'd3
) (
    input  logic       clk_22,
    input  logic       rst,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [1:0] Event,
    output logic [9:0] d_x,
    output logic [9:0] d_y,
    output logic [9:0] r_x,
    output logic [9:0] r_y,
    output logic [9:0] m_x,
    output logic [9:0] m_y,
    output logic       d_valid,
    output logic       r_valid,
    output logic       m_valid,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       game_over
);

    localparam int FW = $clog2(FIRE_PERIOD + 1);
    localparam int HW = $clog2(HIT_TICKS + 1);
    localparam logic [FW-1:0] FIRE_LAST = FW'(FIRE_PERIOD - 1);
    localparam logic [FW-1:0] FIRE_MAX  = FW'(FIRE_PERIOD);
    localparam logic [HW-1:0] HIT_LAST  = HW'(HIT_TICKS - 1);
    localparam logic [9:0]    M_XOFS    = 10'd56;
    localparam logic [9:0]    M_YOFS    = 10'd9;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HIT, S_OVER} state_t;

    state_t        state;
    logic [1:0]    ev_meta, ev_s, ev_prev;
    logic          r_down;
    logic [FW-1:0] fire_tmr;
    logic [HW-1:0] hit_tmr;

    logic          new_ev, r_down_mv, launch_ok;
    logic [9:0]    d_y_mv, r_x_mv, r_y_mv;

    // Candidate next positions; bounds are tested before any subtraction.
    always_comb begin
        new_ev    = (ev_s != 2'b00) && (ev_s != ev_prev);
        d_y_mv    = d_y;
        if (btn_up && !btn_down)
            d_y_mv = (d_y < D_STEP) ? 10'd0 : d_y - D_STEP;
        else if (btn_down && !btn_up)
            d_y_mv = (d_y > Y_MAX - D_STEP) ? Y_MAX : d_y + D_STEP;

        r_y_mv    = r_y;
        r_down_mv = r_down;
        if (r_down) begin
            if (r_y > Y_MAX - R_STEP) begin
                r_y_mv    = Y_MAX;
                r_down_mv = 1'b0;
            end else begin
                r_y_mv = r_y + R_STEP;
            end
        end else begin
            if (r_y < R_STEP) begin
                r_y_mv    = 10'd0;
                r_down_mv = 1'b1;
            end else begin
                r_y_mv = r_y - R_STEP;
            end
        end

        r_x_mv    = (r_x < R_STEP) ? R_X0 : r_x - R_STEP;
        // Launch on the tick the timer reaches FIRE_PERIOD, or any later tick once the robot is far enough right.
        launch_ok = (fire_tmr >= FIRE_LAST) && (r_x_mv >= M_XOFS + M_STEP);
    end

    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ev_meta   <= 2'b00;
            ev_s      <= 2'b00;
            ev_prev   <= 2'b00;
            d_x       <= D_X0;
            d_y       <= D_Y0;
            r_x       <= R_X0;
            r_y       <= 10'd0;
            r_down    <= 1'b1;
            m_x       <= 10'd0;
            m_y       <= 10'd0;
            d_valid   <= 1'b0;
            r_valid   <= 1'b0;
            m_valid   <= 1'b0;
            lives     <= LIVES;
            score     <= 8'd0;
            game_over <= 1'b0;
            fire_tmr  <= '0;
            hit_tmr   <= '0;
        end else begin
            ev_meta <= Event;
            ev_s    <= ev_meta;
            ev_prev <= ev_s;

            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state     <= S_PLAY;
                        d_x       <= D_X0;
                        d_y       <= D_Y0;
                        r_x       <= R_X0;
                        r_y       <= 10'd0;
                        r_down    <= 1'b1;
                        m_x       <= 10'd0;
                        m_y       <= 10'd0;
                        d_valid   <= 1'b1;
                        r_valid   <= 1'b1;
                        m_valid   <= 1'b0;
                        lives     <= LIVES;
                        score     <= 8'd0;
                        game_over <= 1'b0;
                        fire_tmr  <= '0;
                        hit_tmr   <= '0;
                    end
                end

                S_PLAY: begin
                    if (new_ev) begin
                        if (ev_s[1] == 1'b0 || ev_s[0] == 1'b1) begin
                            r_x    <= R_X0;
                            r_y    <= 10'd0;
                            r_down <= 1'b1;
                        end
                        if (ev_s == 2'b01) begin
                            if (score != 8'hFF)
                                score <= score + 8'd1;
                        end else begin
                            if (lives != 2'd0)
                                lives <= lives - 2'd1;
                            if (lives <= 2'd1) begin
                                state     <= S_OVER;
                                game_over <= 1'b1;
                                d_valid   <= 1'b0;
                                r_valid   <= 1'b0;
                                m_valid   <= 1'b0;
                            end else begin
                                state    <= S_HIT;
                                hit_tmr  <= '0;
                                m_valid  <= 1'b0;
                                fire_tmr <= '0;
                            end
                        end
                    end else begin
                        d_y    <= d_y_mv;
                        r_x    <= r_x_mv;
                        r_y    <= r_y_mv;
                        r_down <= r_down_mv;
                        if (m_valid) begin
                            if (m_x < M_STEP)
                                m_valid <= 1'b0;
                            else
                                m_x <= m_x - M_STEP;
                        end else if (launch_ok) begin
                            m_valid  <= 1'b1;
                            m_x      <= r_x_mv - M_XOFS;
                            m_y      <= r_y_mv + M_YOFS;
                            fire_tmr <= '0;
                        end else if (fire_tmr != FIRE_MAX) begin
                            fire_tmr <= fire_tmr + FW'(1);
                        end
                    end
                end

                S_HIT: begin
                    if (hit_tmr == HIT_LAST) begin
                        state   <= S_PLAY;
                        d_y     <= D_Y0;
                        d_valid <= 1'b1;
                    end else begin
                        hit_tmr <= hit_tmr + HW'(1);
                        if (hit_tmr[1:0] == 2'b11)
                            d_valid <= ~d_valid;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: directed table, hand sequences for missile,
// robot-hit latency/saturation and async reset, then random play vs a model.
module tb_sprite_motion_ctrl;

    logic       clk_22 = 1'b0;
    logic       rst, start, btn_up, btn_down;
    logic [1:0] Event;
    logic [9:0] d_x, d_y, r_x, r_y, m_x, m_y;
    logic       d_valid, r_valid, m_valid, game_over;
    logic [1:0] lives;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;

    sprite_motion_ctrl dut (
        .clk_22(clk_22), .rst(rst), .start(start), .btn_up(btn_up),
        .btn_down(btn_down), .Event(Event), .d_x(d_x), .d_y(d_y), .r_x(r_x),
        .r_y(r_y), .m_x(m_x), .m_y(m_y), .d_valid(d_valid), .r_valid(r_valid),
        .m_valid(m_valid), .lives(lives), .score(score), .game_over(game_over)
    );

    always #5 clk_22 = ~clk_22;

    // Reference model: plain integers, game rules applied tick by tick.
    localparam int P_IDLE = 0, P_PLAY = 1, P_HIT = 2, P_OVER = 3;
    int md_y, mr_x, mr_y, mr_dir, mm_x, mm_y, mlives, mscore, mfire, mhitn, mst;
    bit md_v, mr_v, mm_v, mgo;
    bit [1:0] msyncq[$];
    bit [1:0] mprev;

    task automatic model_reset();
        mst = P_IDLE; md_y = 225; mr_x = 560; mr_y = 0; mr_dir = 1;
        mm_x = 0; mm_y = 0; md_v = 0; mr_v = 0; mm_v = 0;
        mlives = 3; mscore = 0; mgo = 0; mfire = 0; mhitn = 0;
        msyncq = {2'b00, 2'b00}; mprev = 2'b00;
    endtask

    task automatic model_reload();
        model_reset();
        mst = P_PLAY; md_v = 1; mr_v = 1;
        msyncq = {2'b00, 2'b00};
    endtask

    task automatic robot_home();
        mr_x = 560; mr_y = 0; mr_dir = 1;
    endtask

    task automatic model_step();
        bit [1:0] evs;
        bit       fresh;
        bit [1:0] s0, s1;
        int       ny;
        evs   = msyncq[0];
        fresh = (evs != 2'b00) && (evs != mprev);
        mprev = evs;
        s1 = msyncq[1];
        s0 = Event;
        case (mst)
            P_IDLE, P_OVER: if (start) begin
                model_reload();
                mprev = evs;
            end
            P_PLAY: begin
                if (fresh) begin
                    if (evs == 2'b01) begin
                        mscore = (mscore < 255) ? mscore + 1 : 255;
                        robot_home();
                    end else begin
                        if (evs == 2'b11) robot_home();
                        mlives = mlives - 1;
                        if (mlives == 0) begin
                            mst = P_OVER; mgo = 1; md_v = 0; mr_v = 0; mm_v = 0;
                        end else begin
                            mst = P_HIT; mhitn = 0; mm_v = 0; mfire = 0;
                        end
                    end
                end else begin
                    if (btn_up && !btn_down) md_y = (md_y - 4 < 0) ? 0 : md_y - 4;
                    if (btn_down && !btn_up) md_y = (md_y + 4 > 450) ? 450 : md_y + 4;
                    ny = mr_y + 2 * mr_dir;
                    if (ny < 0) begin ny = 0; mr_dir = 1; end
                    else if (ny > 450) begin ny = 450; mr_dir = -1; end
                    mr_y = ny;
                    mr_x = (mr_x < 2) ? 560 : mr_x - 2;
                    if (mm_v) begin
                        if (mm_x < 8) mm_v = 0;
                        else mm_x = mm_x - 8;
                    end else begin
                        mfire = (mfire + 1 > 16) ? 16 : mfire + 1;
                        if (mfire == 16 && mr_x >= 64) begin
                            mm_v = 1; mm_x = mr_x - 56; mm_y = mr_y + 9; mfire = 0;
                        end
                    end
                end
            end
            P_HIT: begin
                mhitn = mhitn + 1;
                if (mhitn == 32) begin
                    mst = P_PLAY; md_y = 225; md_v = 1;
                end else if (mhitn % 4 == 0) begin
                    md_v = !md_v;
                end
            end
            default: ;
        endcase
        msyncq = {s1, s0};
    endtask

    function automatic logic [73:0] model_vec();
        return {10'd40, 10'(md_y), 10'(mr_x), 10'(mr_y), 10'(mm_x), 10'(mm_y),
                md_v, mr_v, mm_v, 2'(mlives), 8'(mscore), mgo};
    endfunction

    logic [73:0] dut_vec;
    assign dut_vec = {d_x, d_y, r_x, r_y, m_x, m_y, d_valid, r_valid, m_valid,
                      lives, score, game_over};

    task automatic chk_v(input string name, input logic [73:0] act, input logic [73:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_22);
        model_step();
        #1;
        chk_v("model", dut_vec, model_vec());
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; btn_up = 1'b0; btn_down = 1'b0; Event = 2'b00;
        model_reset();
        repeat (2) @(posedge clk_22);
        #1;
        chk_v("reset_vec", dut_vec,
              {10'd40, 10'd225, 10'd560, 10'd0, 10'd0, 10'd0, 3'b000, 2'd3, 8'd0, 1'b0});
        rst = 1'b0;
    endtask

    typedef struct {
        bit       st, up, dn;
        bit [1:0] ev;
        int       n;
        int       dy, lv, sc;
        bit       go, dv;
    } seg_t;

    seg_t tbl[20];
    int   ev_hold;

    initial begin
        tbl[0]  = '{0, 0, 0, 2'b00,  10, 225, 3, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 2'b00,   1, 225, 3, 0, 0, 1};
        tbl[2]  = '{0, 1, 0, 2'b00,  56,   1, 3, 0, 0, 1};
        tbl[3]  = '{0, 1, 0, 2'b00,   1,   0, 3, 0, 0, 1};
        tbl[4]  = '{0, 1, 0, 2'b00,   3,   0, 3, 0, 0, 1};
        tbl[5]  = '{0, 0, 1, 2'b00, 120, 450, 3, 0, 0, 1};
        tbl[6]  = '{0, 1, 1, 2'b00,   5, 450, 3, 0, 0, 1};
        tbl[7]  = '{0, 0, 0, 2'b01, 200, 450, 3, 1, 0, 1};
        tbl[8]  = '{0, 0, 0, 2'b00,   5, 450, 3, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 2'b01,  10, 450, 3, 2, 0, 1};
        tbl[10] = '{0, 0, 0, 2'b00,   5, 450, 3, 2, 0, 1};
        tbl[11] = '{0, 0, 0, 2'b10,  10, 450, 2, 2, 0, 0};
        tbl[12] = '{0, 0, 0, 2'b01,   8, 450, 2, 2, 0, 0};
        tbl[13] = '{0, 0, 0, 2'b00,  18, 225, 2, 2, 0, 1};
        tbl[14] = '{0, 0, 0, 2'b10,   3, 225, 1, 2, 0, 1};
        tbl[15] = '{0, 0, 0, 2'b00,  40, 225, 1, 2, 0, 1};
        tbl[16] = '{0, 0, 0, 2'b10,   3, 225, 0, 2, 1, 0};
        tbl[17] = '{0, 0, 0, 2'b00,   5, 225, 0, 2, 1, 0};
        tbl[18] = '{1, 0, 0, 2'b00,   1, 225, 3, 0, 0, 1};
        tbl[19] = '{0, 0, 0, 2'b11,   3, 225, 2, 0, 0, 1};

        // Missile launch, flight, retire and relaunch from a fresh game.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 92; k++) begin
            tick();
            if (k == 15) chk_i("m_valid_before_launch", m_valid, 0);
            if (k == 16) begin
                chk_i("m_valid_launch", m_valid, 1);
                chk_i("m_x_launch", m_x, 472);
                chk_i("m_y_launch", m_y, 41);
            end
            if (k == 17) chk_i("m_x_step", m_x, 464);
            if (k == 75) chk_i("m_x_last", m_x, 0);
            if (k == 76) chk_i("m_valid_retire", m_valid, 0);
            if (k == 91) chk_i("m_valid_idle", m_valid, 0);
            if (k == 92) begin
                chk_i("m_valid_relaunch", m_valid, 1);
                chk_i("m_x_relaunch", m_x, 320);
                chk_i("m_y_relaunch", m_y, 193);
            end
        end

        // Robot-hit latency, then score saturation.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk_i("r_x_pre_event", r_x, 550);
        Event = 2'b01;
        tick();
        tick();
        chk_i("r_x_sync_delay", r_x, 546);
        tick();
        chk_i("r_x_respawn", r_x, 560);
        chk_i("r_y_respawn", r_y, 0);
        chk_i("score_first_hit", score, 1);
        Event = 2'b00;
        repeat (3) tick();
        for (int h = 0; h < 256; h++) begin
            Event = 2'b01;
            repeat (3) tick();
            Event = 2'b00;
            repeat (3) tick();
        end
        chk_i("score_saturate", score, 255);

        // Directed table.
        do_reset();
        foreach (tbl[i]) begin
            start = tbl[i].st; btn_up = tbl[i].up; btn_down = tbl[i].dn; Event = tbl[i].ev;
            repeat (tbl[i].n) tick();
            chk_i($sformatf("tbl%0d_d_y", i), d_y, tbl[i].dy);
            chk_i($sformatf("tbl%0d_lives", i), lives, tbl[i].lv);
            chk_i($sformatf("tbl%0d_score", i), score, tbl[i].sc);
            chk_i($sformatf("tbl%0d_game_over", i), game_over, tbl[i].go);
            chk_i($sformatf("tbl%0d_d_valid", i), d_valid, tbl[i].dv);
        end
        start = 1'b0; Event = 2'b00;
        chk_i("r_x_after_both_hit", r_x, 560);
        chk_i("m_valid_in_hit", m_valid, 0);
        repeat (2) tick();

        // Asynchronous reset mid-HIT, no clock edge.
        rst = 1'b1;
        model_reset();
        #1;
        chk_v("async_reset", dut_vec,
              {10'd40, 10'd225, 10'd560, 10'd0, 10'd0, 10'd0, 3'b000, 2'd3, 8'd0, 1'b0});
        rst = 1'b0;

        // Random play against the model.
        ev_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (ev_hold == 0) begin
                Event   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                ev_hold = $urandom_range(1, 40);
            end
            ev_hold--;
            start    = ($urandom_range(0, 30) == 0);
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 1));
            tick();
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                chk_v("rand_async_reset", dut_vec, model_vec());
                rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
